// File: rtl/data_sync_pkg.sv
// Shared constants and elaboration-time helpers for the multi-channel data synchroniser.
// Used by data_sync_ch and data_sync_mc.
package data_sync_pkg;

    localparam int MODE_LEVEL  = 0;
    localparam int MODE_TOGGLE = 1;

    localparam int MIN_STAGES = 2;
    localparam int MIN_CH     = 2;
    localparam int MAX_CH     = 16;

    function automatic int ch_width(input int num_ch);
        return (num_ch <= 1) ? 1 : $clog2(num_ch);
    endfunction

    function automatic bit stages_legal(input int num_stages);
        return num_stages >= MIN_STAGES;
    endfunction

    function automatic bit ch_legal(input int num_ch);
        return (num_ch >= MIN_CH) && (num_ch <= MAX_CH);
    endfunction

endpackage

// File: rtl/data_sync_ch.sv
// One channel: enable synchroniser, edge detect, holding register, pending and overrun flags.
// hold is loaded from the asynchronous bus only on a synchronised event, when it is quasi-static.
module data_sync_ch
    import data_sync_pkg::*;
#(
    parameter int BUS_WIDTH   = 8,
    parameter int NUM_STAGES  = 2,
    parameter int TOGGLE_MODE = MODE_LEVEL
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 bus_enable,
    input  logic [BUS_WIDTH-1:0] unsync_bus,
    input  logic                 grant_clr,
    input  logic                 clr_overrun,
    output logic                 pending,
    output logic [BUS_WIDTH-1:0] hold,
    output logic                 pulse,
    output logic                 overrun
);

    logic [NUM_STAGES-1:0] sync_q, sync_d;
    logic                  prev_q, prev_d;
    logic                  pulse_q, pulse_d;
    logic                  pending_q, pending_d;
    logic                  overrun_q, overrun_d;
    logic [BUS_WIDTH-1:0]  hold_q, hold_d;
    logic                  sync_w;
    logic                  evt;

    assign sync_w = sync_q[NUM_STAGES-1];

    always_comb begin
        sync_d    = {sync_q[NUM_STAGES-2:0], bus_enable};
        prev_d    = sync_w;
        evt       = (TOGGLE_MODE == MODE_TOGGLE) ? (sync_w ^ prev_q) : (sync_w & ~prev_q);
        pulse_d   = evt;
        hold_d    = hold_q;
        pending_d = pending_q;
        overrun_d = overrun_q;

        if (evt) begin
            hold_d    = unsync_bus;
            pending_d = 1'b1;
        end else if (grant_clr) begin
            pending_d = 1'b0;
        end

        // A word being granted this cycle is leaving, so overwriting it is not an overrun.
        if (evt && pending_q && !grant_clr) begin
            overrun_d = 1'b1;
        end else if (clr_overrun) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync_q    <= '0;
            prev_q    <= 1'b0;
            pulse_q   <= 1'b0;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
            hold_q    <= '0;
        end else begin
            sync_q    <= sync_d;
            prev_q    <= prev_d;
            pulse_q   <= pulse_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            hold_q    <= hold_d;
        end
    end

    assign pending = pending_q;
    assign hold    = hold_q;
    assign pulse   = pulse_q;
    assign overrun = overrun_q;

endmodule

// File: rtl/data_sync_mc.sv
// Multi-channel data synchroniser: per-channel capture merged onto one valid/ready stream
// by a round-robin arbiter.
module data_sync_mc
    import data_sync_pkg::*;
#(
    parameter int BUS_WIDTH   = 8,
    parameter int NUM_STAGES  = 2,
    parameter int NUM_CH      = 4,
    parameter int TOGGLE_MODE = MODE_LEVEL,
    parameter int CH_W        = ch_width(NUM_CH)
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic [NUM_CH-1:0]           bus_enable,
    input  logic [NUM_CH*BUS_WIDTH-1:0] unsync_bus,
    input  logic                        out_ready,
    input  logic                        clr_overrun,
    output logic                        out_valid,
    output logic [BUS_WIDTH-1:0]        out_data,
    output logic [CH_W-1:0]             out_ch,
    output logic [NUM_CH-1:0]           enable_pulse_d,
    output logic [NUM_CH-1:0]           overrun
);

    if (!stages_legal(NUM_STAGES)) begin : g_bad_stages
        $error("data_sync_mc: NUM_STAGES must be >= 2");
    end
    if (!ch_legal(NUM_CH)) begin : g_bad_ch
        $error("data_sync_mc: NUM_CH must be in 2..16");
    end

    logic [NUM_CH-1:0]    pending_w;
    logic [NUM_CH-1:0]    grant_clr_w;
    logic [BUS_WIDTH-1:0] hold_w [NUM_CH];

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        data_sync_ch #(
            .BUS_WIDTH  (BUS_WIDTH),
            .NUM_STAGES (NUM_STAGES),
            .TOGGLE_MODE(TOGGLE_MODE)
        ) u_ch (
            .CLK        (CLK),
            .RST        (RST),
            .bus_enable (bus_enable[gi]),
            .unsync_bus (unsync_bus[gi*BUS_WIDTH +: BUS_WIDTH]),
            .grant_clr  (grant_clr_w[gi]),
            .clr_overrun(clr_overrun),
            .pending    (pending_w[gi]),
            .hold       (hold_w[gi]),
            .pulse      (enable_pulse_d[gi]),
            .overrun    (overrun[gi])
        );
    end

    logic                 out_valid_q, out_valid_d;
    logic [BUS_WIDTH-1:0] out_data_q, out_data_d;
    logic [CH_W-1:0]      out_ch_q, out_ch_d;
    logic [CH_W-1:0]      last_q, last_d;

    logic            grant_found;
    logic [CH_W-1:0] grant_idx;
    logic [CH_W-1:0] probe_idx;
    logic            load;

    // Search starts just after the last grant, wrapping modulo NUM_CH (which need not be 2^n).
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        probe_idx   = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            probe_idx = CH_W'((int'(last_q) + k) % NUM_CH);
            if (!grant_found && pending_w[probe_idx]) begin
                grant_found = 1'b1;
                grant_idx   = probe_idx;
            end
        end
    end

    assign load = (!out_valid_q || out_ready) && grant_found;

    always_comb begin
        grant_clr_w = '0;
        if (load) begin
            grant_clr_w[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        last_d      = last_q;
        if (load) begin
            out_valid_d = 1'b1;
            out_data_d  = hold_w[grant_idx];
            out_ch_d    = grant_idx;
            last_d      = grant_idx;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            last_q      <= CH_W'(NUM_CH - 1);
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            last_q      <= last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;

endmodule
